// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic                  dm_byte_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_f_o
);

  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } stateT;

  stateT         state;
  stateT         stateNext;
  logic [LW-1:0] latCnt;
  logic [LW-1:0] latNext;
  logic [SW-1:0] starveCnt;
  logic [SW-1:0] starveNext;
  logic          ownerDm;
  logic          ownerNext;
  logic          done;
  logic          window;
  logic          guard;
  logic          gntIf;
  logic          gntDm;
  logic          rdGnt;

  assign done   = (state == RD_WAIT) && (latCnt == LW'(1));
  assign window = !rst && ((state == IDLE) || done);
  assign guard  = if_req_i && (starveCnt == SW'(STARVE_LIMIT));
  assign gntDm  = window && dm_req_i && !guard;
  assign gntIf  = window && if_req_i && !gntDm;
  assign rdGnt  = gntIf || (gntDm && !dm_we_i);

  // Grant outputs, memory port mux and read-return steering
  always_comb begin
    if_gnt_o    = gntIf;
    dm_gnt_o    = gntDm;
    stall_f_o   = !rst && if_req_i && !gntIf;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_byte_o  = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      gntDm: begin
        mem_en_o    = 1'b1;
        mem_we_o    = dm_we_i;
        mem_byte_o  = dm_byte_i;
        mem_addr_o  = dm_addr_i;
        mem_wdata_o = dm_wdata_i;
      end
      gntIf: begin
        mem_en_o   = 1'b1;
        mem_addr_o = if_addr_i;
      end
      default: begin
      end
    endcase
    if_rvalid_o = !rst && done && !ownerDm;
    dm_rvalid_o = !rst && done && ownerDm;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
  end

  // Next state: latency countdown, read reload, starvation tracking
  always_comb begin
    stateNext  = state;
    latNext    = latCnt;
    ownerNext  = ownerDm;
    starveNext = starveCnt;
    if (state == RD_WAIT) begin
      latNext = latCnt - LW'(1);
      if (done) stateNext = IDLE;
    end
    if (gntIf || gntDm) begin
      if (rdGnt) begin
        stateNext = RD_WAIT;
        latNext   = LW'(MEM_LATENCY);
        ownerNext = gntDm;
      end else begin
        stateNext = IDLE;
      end
    end
    if (!if_req_i || gntIf) begin
      starveNext = '0;
    end else if (gntDm && (starveCnt != SW'(STARVE_LIMIT))) begin
      starveNext = starveCnt + SW'(1);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      latCnt    <= '0;
      starveCnt <= '0;
      ownerDm   <= 1'b0;
    end else begin
      state     <= stateNext;
      latCnt    <= latNext;
      starveCnt <= starveNext;
      ownerDm   <= ownerNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic.
// A cycle-count reference model predicts grants; queues hold read data.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int SL  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic          dm_byte_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic          mem_byte_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_f_o;

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_byte_i  (dm_byte_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_gnt_o   (dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o (dm_rdata_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_byte_o (mem_byte_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .stall_f_o  (stall_f_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int at;
    bit dm;
  } pendT;
  typedef struct {
    int          at;
    logic [31:0] addr;
  } rdT;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        byteOp;
  } wrT;

  pendT        pend[$];
  rdT          rdIss[$];
  wrT          wrQ[$];
  logic [31:0] ifQ[$];
  logic [31:0] dmQ[$];

  int freeAt    = 0;
  int streak    = 0;
  int lastIfGnt = -1;
  int lastDmGnt = -1;
  int lastIfRv  = -1;
  int dmRvCount = 0;
  int run       = 0;
  int lastRun   = -1;
  int rstFall   = 0;
  int cnt0      = 0;

  function automatic logic [31:0] memF(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory: returns the word for a read exactly LAT cycles after issue
  always @(posedge clk) begin
    #1;
    while (rdIss.size() > 0 && rdIss[0].at < cyc) void'(rdIss.pop_front());
    if (rdIss.size() > 0 && rdIss[0].at == cyc) mem_rdata_i = memF(rdIss[0].addr);
    else mem_rdata_i = $urandom | 32'h1;
  end

  // Monitor: reference model of grants/timing plus data scoreboards
  always @(negedge clk) begin : mon
    logic        win;
    logic        expIf;
    logic        expDm;
    logic        expIfRv;
    logic        expDmRv;
    logic        eWe;
    logic        eBy;
    logic [31:0] eAddr;
    logic [31:0] eWd;
    wrT          w;
    if (rst) begin
      check("rst_outputs", 64'({if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o,
                                mem_en_o, mem_we_o, mem_byte_o, stall_f_o,
                                |if_rdata_o, |dm_rdata_o, |mem_addr_o,
                                |mem_wdata_o}), 64'(0));
      freeAt = 0;
      streak = 0;
      run    = 0;
      pend.delete();
    end else begin
      win   = cyc >= freeAt;
      expDm = win && dm_req_i && !(if_req_i && streak == SL);
      expIf = win && if_req_i && !expDm;
      eWe   = 1'b0;
      eBy   = 1'b0;
      eAddr = '0;
      eWd   = '0;
      if (expDm) begin
        eWe   = dm_we_i;
        eBy   = dm_byte_i;
        eAddr = dm_addr_i;
        eWd   = dm_wdata_i;
      end else if (expIf) begin
        eAddr = if_addr_i;
      end
      check("gnt_stall", 64'({if_gnt_o, dm_gnt_o, stall_f_o}),
            64'({expIf, expDm, if_req_i && !expIf}));
      check("mem_ctl", 64'({mem_en_o, mem_we_o, mem_byte_o}),
            64'({expIf | expDm, eWe, eBy}));
      check("mem_addr", 64'(mem_addr_o), 64'(eAddr));
      check("mem_wdata", 64'(mem_wdata_o), 64'(eWd));
      expIfRv = pend.size() > 0 && pend[0].at == cyc && !pend[0].dm;
      expDmRv = pend.size() > 0 && pend[0].at == cyc && pend[0].dm;
      check("rvalid", 64'({if_rvalid_o, dm_rvalid_o}), 64'({expIfRv, expDmRv}));
      if (expIfRv) begin
        if (ifQ.size() == 0) check("if_sb_empty", 64'(1), 64'(0));
        else check("if_rdata", 64'(if_rdata_o), 64'(ifQ.pop_front()));
      end else begin
        check("if_rdata_idle", 64'(if_rdata_o), 64'(0));
      end
      if (expDmRv) begin
        if (dmQ.size() == 0) check("dm_sb_empty", 64'(1), 64'(0));
        else check("dm_rdata", 64'(dm_rdata_o), 64'(dmQ.pop_front()));
      end else begin
        check("dm_rdata_idle", 64'(dm_rdata_o), 64'(0));
      end
      if (pend.size() > 0 && pend[0].at == cyc) void'(pend.pop_front());
      if (mem_en_o && mem_we_o) begin
        if (wrQ.size() == 0) begin
          check("store_unexpected", 64'(1), 64'(0));
        end else begin
          w = wrQ.pop_front();
          check("store", 64'({mem_byte_o, mem_addr_o, mem_wdata_o[30:0]}),
                64'({w.byteOp, w.addr, w.wdata[30:0]}));
        end
      end
      if (mem_en_o && !mem_we_o) rdIss.push_back('{at: cyc + LAT, addr: mem_addr_o});
      if (if_gnt_o) lastIfGnt = cyc;
      if (dm_gnt_o) lastDmGnt = cyc;
      if (if_rvalid_o) lastIfRv = cyc;
      if (dm_rvalid_o) dmRvCount++;
      if (if_gnt_o) begin
        lastRun = run;
        run     = 0;
      end else if (!if_req_i) begin
        run = 0;
      end else if (dm_gnt_o) begin
        run++;
      end
      if (expIf || expDm) begin
        if (expIf || !dm_we_i) begin
          freeAt = cyc + LAT;
          pend.push_back('{at: cyc + LAT, dm: expDm});
        end else begin
          freeAt = cyc + 1;
        end
      end
      if (!if_req_i || expIf) streak = 0;
      else if (expDm && streak < SL) streak++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ifFetch(input logic [31:0] a);
    int n = 0;
    if_addr_i = a;
    if_req_i  = 1'b1;
    ifQ.push_back(memF(a));
    forever begin
      @(negedge clk);
      if (if_gnt_o) break;
      n++;
      if (n > 100) begin
        check("if_gnt_timeout", 64'(if_gnt_o), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    if_req_i = 1'b0;
  endtask

  task automatic dmAccess(input logic we, input logic by,
                          input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    dm_we_i    = we;
    dm_byte_i  = by;
    dm_addr_i  = a;
    dm_wdata_i = wd;
    dm_req_i   = 1'b1;
    if (we) wrQ.push_back('{addr: a, wdata: wd, byteOp: by});
    else dmQ.push_back(memF(a));
    forever begin
      @(negedge clk);
      if (dm_gnt_o) break;
      n++;
      if (n > 100) begin
        check("dm_gnt_timeout", 64'(dm_gnt_o), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    dm_byte_i  = 1'b0;
    dm_wdata_i = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_byte_i   = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    mem_rdata_i = '0;

    fork
      ifFetch(32'h30);
      dmAccess(1'b0, 1'b0, 32'h34, 32'h0);
      begin
        idle(2);
        rst     = 1'b0;
        rstFall = cyc;
      end
    join
    idle(LAT + 1);
    check("first_gnt_after_rst", 64'(lastDmGnt), 64'(rstFall));
    check("contend_if_gnt", 64'(lastIfGnt - lastDmGnt), 64'(LAT));

    ifFetch(32'h10);
    idle(LAT + 1);
    check("fetch_latency", 64'(lastIfRv - lastIfGnt), 64'(LAT));

    fork
      dmAccess(1'b1, 1'b1, 32'h100, 32'hAB);
      ifFetch(32'h44);
    join
    idle(LAT + 1);
    check("store_then_fetch", 64'(lastIfGnt - lastDmGnt), 64'(1));

    fork
      ifFetch(32'h48);
      for (int i = 0; i < 6; i++) dmAccess(1'b0, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
    join
    idle(LAT + 1);
    check("starve_run", 64'(lastRun), 64'(SL));

    dmAccess(1'b0, 1'b0, 32'h300, 32'h0);
    rst = 1'b1;
    idle(1);
    rst     = 1'b0;
    rstFall = cyc;
    void'(dmQ.pop_back());
    cnt0 = dmRvCount;
    dmAccess(1'b0, 1'b0, 32'h304, 32'h0);
    idle(LAT + 1);
    check("post_rst_gnt", 64'(lastDmGnt), 64'(rstFall));
    check("abandoned_rvalid", 64'(dmRvCount), 64'(cnt0 + 1));

    fork
      for (int i = 0; i < 40; i++) begin
        int k = $urandom_range(0, 3);
        if (k > 0) idle(k);
        ifFetch($urandom & 32'h0000_FFFC);
      end
      for (int j = 0; j < 60; j++) begin
        int k = $urandom_range(0, 2);
        if (k > 0) idle(k);
        dmAccess(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom & 32'h0000_FFFC, $urandom);
      end
    join
    idle(LAT + 2);
    check("drain_if", 64'(ifQ.size()), 64'(0));
    check("drain_dm", 64'(dmQ.size()), 64'(0));
    check("drain_wr", 64'(wrQ.size()), 64'(0));
    check("drain_pend", 64'(pend.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
